alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the team's combinational 4-bit ALU. It provides a WIDTH-bit arithmetic/logic unit with the same `{arit, ALUOp}` operation encoding, an internal accumulator, a signed-overflow flag, and a multi-cycle shift-add unsigned multiplier with a start/busy/done handshake. Its place is the datapath of the practice CPU, between the register file and the writeback mux.

## Interface

**Parameters**
- `WIDTH`, default 8: operand and result width; must be ≥ 2.

**Ports**
- `clk`  in  1  the single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; accepted only while `busy`=0.
- `A`  in  WIDTH  operand A; ignored when `acc_en`=1.
- `B`  in  WIDTH  operand B.
- `ALUOp`  in  2  operation select.
- `arit`  in  1  1 selects arithmetic, 0 selects logic.
- `mul`  in  1  1 selects unsigned multiply; overrides `arit` and `ALUOp`.
- `acc_en`  in  1  1 replaces A with the accumulator.
- `R`  out  WIDTH  result, or the product's low half.
- `R_hi`  out  WIDTH  product's high half; 0 for non-multiply operations.
- `zero`, `carry`, `sign`, `overflow`  out  1 each  registered flags.
- `busy`  out  1  a multiply is in progress.
- `done`  out  1  one-cycle pulse when a result is valid.

## Operation

**Operand capture.** All operands and the operation select are sampled on the accepting edge. The effective A operand is `Aeff = acc_en ? acc : A`.

**Arithmetic operations (`arit`=1)**
- 00: `Aeff + B`
- 01: `Aeff + ~B + 1`
- 10: `Aeff + 1`
- 11: `0 + ~B + 1`, i.e. −B

**Logic operations (`arit`=0)**
- 00: AND
- 01: OR
- 10: XOR
- 11: `~Aeff`

**Width rule.** Arithmetic is computed as WIDTH+1 bits; bit WIDTH is `carry`. For subtraction, `carry`=1 means no borrow.

**Flags for arithmetic operations**
- `sign` = `R[WIDTH-1]`.
- `overflow` = signed two's-complement overflow of the actual adder operands (OP1, OP2, Cin).
- `zero` = (R == 0).

**Flags for logic operations**
- `carry` = 0, `sign` = 0, `overflow` = 0 (never X).
- `zero` = (R == 0).

**Multiply (`mul`=1)**
- Computes `{R_hi, R} = Aeff * B`, unsigned, radix-2 shift-add, one bit per cycle.
- `zero` = (2·WIDTH-bit product == 0).
- `carry` = (R_hi != 0).
- `sign` = 0, `overflow` = 0.

**Accumulator**
- `acc` is a WIDTH-bit register. It loads R whenever `done` is asserted, including the low half of a product.
- Reset value of `acc` is 0.

**State machine: IDLE, MUL.**
- In IDLE with `start`=1 and `mul`=0: R, R_hi (=0), the flags, and `acc` are written on that edge. `done`=1 for the following cycle. The FSM stays in IDLE.
- In IDLE with `start`=1 and `mul`=1: the multiplicand, multiplier and counter are loaded. The FSM moves to MUL and `busy`=1.
- In MUL: the FSM performs one iteration per edge. After the WIDTH-th iteration edge, R, R_hi, the flags and `acc` are written, the FSM returns to IDLE, `busy`=0, and `done`=1 for one cycle.
- In MUL, `start` is ignored with no queuing. `A`, `B` and the select inputs may change freely.
- R, R_hi and the flags hold their previous values until the next completion. They do not change during a multiply.

**Reset.** Asserting `reset_n`=0 at any time, including mid-multiply, immediately clears R, R_hi, all flags, `busy`, `done`, `acc`, the counter and the partial product to 0, and forces IDLE. The in-flight operation is discarded.

## Timing
- Single-cycle operations: latency 1. Result and flags are valid, and `done`=1, in the cycle after the accepting edge. `busy` stays 0.
- Multiply: `busy` rises in the cycle after the accepting edge and stays high for WIDTH cycles. `done` pulses in the cycle after the WIDTH-th iteration edge, in the same cycle that `busy` falls.
- Back-to-back single-cycle operations are accepted on consecutive edges. `done` remains high across them.
- A new `start` is accepted in the same cycle that `done` is high for a completed multiply.
- `done` is never high while `busy` is high.
- Reset values: every output is 0.

## Test plan
- **Reset and first add:** hold `reset_n`=0 → all outputs 0. Release, then A=FF, B=01, arit=1, ALUOp=00, start → next cycle R=00, carry=1, zero=1, sign=0, overflow=0, done=1 for exactly one cycle.
- **Overflow and subtract:** A=7F, B=01 add → R=80, sign=1, overflow=1, carry=0. A=05, B=07, ALUOp=01 → R=FE, carry=0, sign=1, overflow=0.
- **Accumulator:** compute R=10, then acc_en=1, A=AA (ignored), B=05, add → R=15. Repeat → R=1A.
- **Multiply:** A=FF, B=FF, mul=1, start; pulse start again at busy cycle 3 → busy=1 for 8 cycles, then {R_hi,R}=FE01, carry=1, zero=0, exactly one done. The second start is ignored.
- **Reset mid-multiply:** assert `reset_n`=0 during busy cycle 4 → busy, done, R, R_hi and acc are 0 immediately, with no clock edge. After release, an add of 01+01 → R=02.
- **Edge encodings:** arit=1, ALUOp=11, B=00 → R=00, carry=1, zero=1. arit=0, ALUOp=11, A=0F → R=F0, carry=0, sign=0, overflow=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with accumulator, flags and a shift-add unsigned multiplier.
// Latency: ALU ops complete 1 cycle after the accepting edge; a multiply takes WIDTH cycles of busy, then done.
// Backpressure: start is accepted only while busy=0; a start during a multiply is dropped, not queued.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       ALUOp,
   input  logic             arit,
   input  logic             mul,
   input  logic             acc_en,
   output logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] R_hi,
   output logic             zero,
   output logic             carry,
   output logic             sign,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   a_eff;
   logic [WIDTH-1:0]   op1;
   logic [WIDTH-1:0]   op2;
   logic               cin;
   logic [WIDTH:0]     sum;
   logic               ovf;
   logic [WIDTH-1:0]   logic_res;
   logic [WIDTH-1:0]   alu_r;

   logic [WIDTH:0]     add_hi;
   logic [2*WIDTH-1:0] prod_nxt;
   logic               mul_last;

   // Single-cycle datapath: select adder operands, add at WIDTH+1 bits, and the logic unit.
   always_comb begin
      a_eff = acc_en ? acc : A;
      op1   = a_eff;
      op2   = B;
      cin   = 1'b0;
      case (ALUOp)
         2'b00: begin
            op2 = B;
            cin = 1'b0;
         end
         2'b01: begin
            op2 = ~B;
            cin = 1'b1;
         end
         2'b10: begin
            op2 = '0;
            cin = 1'b1;
         end
         default: begin
            op1 = '0;
            op2 = ~B;
            cin = 1'b1;
         end
      endcase
      sum = {1'b0, op1} + {1'b0, op2} + (WIDTH+1)'(cin);
      // Signed overflow: operands agree in sign but the result does not.
      ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      case (ALUOp)
         2'b00:   logic_res = a_eff & B;
         2'b01:   logic_res = a_eff | B;
         2'b10:   logic_res = a_eff ^ B;
         default: logic_res = ~a_eff;
      endcase
      alu_r = arit ? sum[WIDTH-1:0] : logic_res;
   end

   // One radix-2 shift-add step: conditionally add the multiplicand to the high half, then shift right.
   always_comb begin
      add_hi   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_nxt = {add_hi, prod[WIDTH-1:1]};
      mul_last = (cnt == CW'(WIDTH-1));
   end

   // Control FSM plus all registered results; outputs only change on completion or reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         acc      <= '0;
         mcand    <= '0;
         prod     <= '0;
         cnt      <= '0;
         R        <= '0;
         R_hi     <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         sign     <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (mul) begin
                     mcand <= a_eff;
                     prod  <= {{WIDTH{1'b0}}, B};
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= S_MUL;
                  end else begin
                     R        <= alu_r;
                     R_hi     <= '0;
                     acc      <= alu_r;
                     zero     <= (alu_r == '0);
                     carry    <= arit & sum[WIDTH];
                     sign     <= arit & sum[WIDTH-1];
                     overflow <= arit & ovf;
                     done     <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               prod <= prod_nxt;
               cnt  <= cnt + 1'b1;
               if (mul_last) begin
                  R        <= prod_nxt[WIDTH-1:0];
                  R_hi     <= prod_nxt[2*WIDTH-1:WIDTH];
                  acc      <= prod_nxt[WIDTH-1:0];
                  zero     <= (prod_nxt == '0);
                  carry    <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                  sign     <= 1'b0;
                  overflow <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, multi-cycle corner sequences and random ops against an arithmetic model.
// Latency: results sampled on the falling edge after the completing rising edge.
// Backpressure: waits on done are bounded by a cycle budget; an expired wait counts as a failure.
module tb_alu_seq;

   localparam int W = 8;

   typedef struct packed {
      logic [7:0] rhi;
      logic [7:0] r;
      logic       z;
      logic       c;
      logic       s;
      logic       v;
   } res_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       arit;
      logic [1:0] op;
      logic       acc_en;
      res_t       exp;
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic [1:0] ALUOp;
   logic       arit;
   logic       mul;
   logic       acc_en;
   logic [7:0] R;
   logic [7:0] R_hi;
   logic       zero;
   logic       carry;
   logic       sign;
   logic       overflow;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .A(A), .B(B), .ALUOp(ALUOp),
      .arit(arit), .mul(mul), .acc_en(acc_en), .R(R), .R_hi(R_hi), .zero(zero),
      .carry(carry), .sign(sign), .overflow(overflow), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // done and busy must never be high together
   always @(negedge clk) if (reset_n && busy && done) overlap++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic res_t outs();
      res_t o;
      o.rhi = R_hi; o.r = R; o.z = zero; o.c = carry; o.s = sign; o.v = overflow;
      return o;
   endfunction

   function automatic int sx(input int v);
      return (v >= (1 << (W-1))) ? v - (1 << W) : v;
   endfunction

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic res_t model(input int a, input int b, input bit ar, input int op, input bit m);
      res_t x;
      int t;
      int sr;
      int mask;
      mask = (1 << W) - 1;
      x = '0;
      sr = 0;
      if (m) begin
         t = a * b;
         x.r = 8'(t & mask);
         x.rhi = 8'(t >> W);
         x.z = (t == 0);
         x.c = ((t >> W) != 0);
      end else if (ar) begin
         case (op)
            0: begin t = a + b;              sr = sx(a) + sx(b); end
            1: begin t = a + (mask - b) + 1; sr = sx(a) - sx(b); end
            2: begin t = a + 1;              sr = sx(a) + 1;     end
            default: begin t = (mask - b) + 1; sr = -sx(b);     end
         endcase
         x.r = 8'(t & mask);
         x.c = (t > mask);
         x.s = x.r[W-1];
         x.v = (sr > 127) || (sr < -128);
         x.z = (x.r == 0);
      end else begin
         case (op)
            0: t = a & b;
            1: t = a | b;
            2: t = a ^ b;
            default: t = (~a) & mask;
         endcase
         x.r = 8'(t);
         x.z = (x.r == 0);
      end
      return x;
   endfunction

   function automatic vec_t mk(input logic [7:0] a, b, input logic ar, input logic [1:0] op,
                               input logic ae, input logic [7:0] r, input logic z, c, s, v);
      vec_t t;
      t.a = a; t.b = b; t.arit = ar; t.op = op; t.acc_en = ae;
      t.exp.rhi = 8'h00; t.exp.r = r; t.exp.z = z; t.exp.c = c; t.exp.s = s; t.exp.v = v;
      return t;
   endfunction

   task automatic drive(input logic [7:0] a, b, input logic ar, input logic [1:0] op,
                        input logic m, ae);
      A = a; B = b; arit = ar; ALUOp = op; mul = m; acc_en = ae; start = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   vec_t tbl[15];
   res_t exp_r;
   int   bc;
   int   hold_err;
   bit   seen;
   bit   pulsed;
   int   m_acc;
   int   ra, rb, rop;
   bit   rar, rm, rae;

   initial begin
      reset_n = 1'b0; start = 1'b0; A = '0; B = '0; ALUOp = '0;
      arit = 1'b0; mul = 1'b0; acc_en = 1'b0;

      tbl[0]  = mk(8'hFF, 8'h01, 1, 2'b00, 0, 8'h00, 1, 1, 0, 0);
      tbl[1]  = mk(8'h7F, 8'h01, 1, 2'b00, 0, 8'h80, 0, 0, 1, 1);
      tbl[2]  = mk(8'h05, 8'h07, 1, 2'b01, 0, 8'hFE, 0, 0, 1, 0);
      tbl[3]  = mk(8'h08, 8'h08, 1, 2'b00, 0, 8'h10, 0, 0, 0, 0);
      tbl[4]  = mk(8'hAA, 8'h05, 1, 2'b00, 1, 8'h15, 0, 0, 0, 0);
      tbl[5]  = mk(8'hAA, 8'h05, 1, 2'b00, 1, 8'h1A, 0, 0, 0, 0);
      tbl[6]  = mk(8'h33, 8'h00, 1, 2'b11, 0, 8'h00, 1, 1, 0, 0);
      tbl[7]  = mk(8'h0F, 8'h00, 0, 2'b11, 0, 8'hF0, 0, 0, 0, 0);
      tbl[8]  = mk(8'hF0, 8'h3C, 0, 2'b00, 0, 8'h30, 0, 0, 0, 0);
      tbl[9]  = mk(8'hF0, 8'h0F, 0, 2'b01, 0, 8'hFF, 0, 0, 0, 0);
      tbl[10] = mk(8'h5A, 8'h5A, 0, 2'b10, 0, 8'h00, 1, 0, 0, 0);
      tbl[11] = mk(8'hFF, 8'h00, 1, 2'b10, 0, 8'h00, 1, 1, 0, 0);
      tbl[12] = mk(8'h00, 8'h80, 1, 2'b11, 0, 8'h80, 0, 0, 1, 1);
      tbl[13] = mk(8'h00, 8'h00, 0, 2'b11, 1, 8'h7F, 0, 0, 0, 0);
      tbl[14] = mk(8'h07, 8'h05, 1, 2'b01, 0, 8'h02, 0, 1, 0, 0);

      // Reset state
      @(negedge clk);
      chk("reset_outputs", {outs(), busy, done}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Table vectors, issued back to back so done stays high throughout
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].arit, tbl[i].op, 1'b0, tbl[i].acc_en);
         @(negedge clk);
         chk($sformatf("vec%0d_result", i), outs(), tbl[i].exp);
         chk($sformatf("vec%0d_done_busy", i), {done, busy}, 2'b10);
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_drops_after_last_vec", {done, busy}, 2'b00);

      // Multiply FF*FF with an ignored start pulse mid-flight
      drive(8'h01, 8'h02, 1, 2'b00, 0, 0);
      @(negedge clk);
      chk("pre_mul_add", R, 8'h03);
      drive(8'hFF, 8'hFF, 0, 2'b10, 1, 0);
      @(negedge clk);
      start = 1'b0;
      bc = 0; hold_err = 0; seen = 0; pulsed = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         if (done) seen = 1;
         else begin
            if (busy) bc++;
            if (busy && (R !== 8'h03 || R_hi !== 8'h00)) hold_err++;
            if (bc == 3 && busy && !pulsed) begin
               A = 8'h01; B = 8'h01; mul = 1'b1; start = 1'b1; pulsed = 1;
            end else start = 1'b0;
            A = 8'(A + 8'h11);
            @(negedge clk);
         end
      end
      chk("mul_done_seen", seen, 1'b1);
      chk("mul_busy_cycles", bc, 8);
      chk("mul_result_held_while_busy", hold_err, 0);
      exp_r = '0; exp_r.rhi = 8'hFE; exp_r.r = 8'h01; exp_r.c = 1'b1;
      chk("mul_ff_ff", outs(), exp_r);
      chk("mul_busy_low_at_done", busy, 1'b0);
      // Start accepted in the done cycle, using acc = product low half
      drive(8'hAA, 8'h01, 1, 2'b00, 0, 1);
      @(negedge clk);
      start = 1'b0;
      chk("acc_after_mul", {R, R_hi, done, busy}, {8'h02, 8'h00, 2'b10});
      bc = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (busy || done) bc++;
      end
      chk("ignored_start_no_activity", bc, 0);

      // Reset mid-multiply
      drive(8'h0F, 8'h0F, 0, 2'b00, 1, 0);
      @(negedge clk);
      start = 1'b0;
      bc = 0;
      for (int c = 0; c < 20 && bc < 4; c++) begin
         if (busy) bc++;
         if (bc < 4) @(negedge clk);
      end
      chk("reached_busy_cycle4", bc, 4);
      reset_n = 1'b0;
      #1;
      chk("async_reset_clears", {outs(), busy, done}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(8'h00, 8'h01, 1, 2'b00, 0, 1);
      @(negedge clk);
      chk("acc_cleared_by_reset", {R, done}, {8'h01, 1'b1});
      drive(8'h01, 8'h01, 1, 2'b00, 0, 0);
      @(negedge clk);
      start = 1'b0;
      chk("add_after_reset", {R, done}, {8'h02, 1'b1});

      // Random operations against the model
      do_reset();
      m_acc = 0;
      for (int n = 0; n < 300; n++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         rop = int'($urandom_range(0, 3));
         rar = 1'($urandom);
         rm = ($urandom_range(0, 3) == 0);
         rae = ($urandom_range(0, 3) == 0);
         exp_r = model(rae ? m_acc : ra, rb, rar, rop, rm);
         drive(8'(ra), 8'(rb), rar, 2'(rop), rm, rae);
         @(negedge clk);
         seen = 0;
         for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1;
            else begin
               A = 8'($urandom); B = 8'($urandom); ALUOp = 2'($urandom);
               arit = 1'($urandom); mul = 1'($urandom); acc_en = 1'($urandom);
               start = 1'($urandom);
               @(negedge clk);
            end
         end
         chk($sformatf("rnd%0d_done", n), seen, 1'b1);
         chk($sformatf("rnd%0d_result", n), outs(), exp_r);
         m_acc = int'(exp_r.r);
      end
      start = 1'b0;
      @(negedge clk);

      chk("done_busy_never_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
